fir_mac_sequencer: RTL and testbench

Controls the filter's single multiply-accumulate datapath. On each new input sample it shifts the sample delay line, then steps through all taps, issuing coefficient and history addresses. It drives clear and enable to the accumulator register, allowing for the multiplier pipeline latency, and flags when the filtered result is ready. It sits between the sample-rate strobe source and the coefficient ROM, sample RAM, multiplier and accumulator of the FILTRO path.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/valid_delay.sv | 45 ++++
 rtl/fir_mac_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FILTRO multiply-accumulate path.
// Holds the sequencer state encoding, the default sample/coefficient width,
// the derived accumulator width and the supported tap-count and multiplier
// latency limits.
package fir_pkg;

  // Default sample/coefficient width and the matching accumulator width.
  localparam int CANT_BITS_DEF = 25;
  localparam int ACC_W         = 2 * CANT_BITS_DEF - 1;

  // Supported configuration range.
  localparam int N_TAPS_MIN  = 2;
  localparam int N_TAPS_MAX  = 256;
  localparam int MUL_LAT_MAX = 4;

  // Sequencer state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    MAC   = ST_MAC,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Width of a tap index; never narrower than one bit.
  function automatic int tap_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// valid_delay: resettable delay line for a single-bit qualifier.
// The output is always a register: DEPTH=0 gives one stage, each extra unit
// of DEPTH adds one more. The caller feeds the next-cycle value of the flag,
// so the output trails the registered flag by exactly DEPTH cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, empties the pipe
//   din  - next-cycle value of the flag to delay
//   dout - delayed flag (registered)
module valid_delay
  import fir_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH:0] pipe_r;

  if (DEPTH == 0) begin : g_single
    // Single output register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_r <= 1'b0;
      end else begin
        pipe_r <= din;
      end
    end
  end else begin : g_chain
    // Shift chain: new value enters at bit 0, leaves at bit DEPTH.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_r <= '0;
      end else begin
        pipe_r <= {pipe_r[DEPTH-1:0], din};
      end
    end
  end

  assign dout = pipe_r[DEPTH];

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control for the FIR filter's single MAC datapath.
// On each accepted sample strobe it shifts the sample delay line, walks all
// taps issuing coefficient/history addresses, clears and enables the
// accumulator (allowing for multiplier latency) and pulses out_valid when
// the sum is final. Strobes arriving while busy are dropped and flagged.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   sample_stb - one-cycle pulse: new input sample present
//   ovr_clr    - synchronous clear of overrun
//   shift_en   - delay line loads new sample and shifts
//   tap_addr   - coefficient/history index (0 outside MAC)
//   acc_clr    - synchronous accumulator clear
//   acc_en     - accumulator adds current product
//   out_valid  - one-cycle pulse: accumulator holds finished sum
//   busy       - high in every state except IDLE
//   overrun    - sticky: a strobe was dropped while busy
// All outputs are registered.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int cant_bits = CANT_BITS_DEF,
  parameter int N_TAPS    = 8,
  parameter int MUL_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_stb,
  input  logic                      ovr_clr,
  output logic                      shift_en,
  output logic [$clog2(N_TAPS)-1:0] tap_addr,
  output logic                      acc_clr,
  output logic                      acc_en,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int               TAP_W      = tap_w(N_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(N_TAPS - 1);
  localparam logic [2:0]       DRAIN_LAST = (MUL_LAT > 0) ? 3'(MUL_LAT - 1) : 3'd0;

  // Out-of-range configurations leave a marker scope in the hierarchy.
  if ((cant_bits < 2) || (N_TAPS < N_TAPS_MIN) || (N_TAPS > N_TAPS_MAX) ||
      (MUL_LAT < 0) || (MUL_LAT > MUL_LAT_MAX)) begin : g_bad_params
  end

  state_t           state_r;
  logic [TAP_W-1:0] tap_addr_r;
  logic [2:0]       drain_cnt_r;
  logic             shift_en_r;
  logic             acc_clr_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic             issue_nxt_s;
  logic             acc_en_s;

  // Next-cycle value of the issue flag: high for every cycle spent in MAC.
  always_comb begin
    issue_nxt_s = 1'b0;
    if (state_r == SHIFT) begin
      issue_nxt_s = 1'b1;
    end else if ((state_r == MAC) && (tap_addr_r != TAP_LAST)) begin
      issue_nxt_s = 1'b1;
    end else begin
      issue_nxt_s = 1'b0;
    end
  end

  // Sequencer FSM, tap/drain counters, registered outputs and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tap_addr_r  <= '0;
      drain_cnt_r <= 3'd0;
      shift_en_r  <= 1'b0;
      acc_clr_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      shift_en_r  <= 1'b0;
      acc_clr_r   <= 1'b0;
      out_valid_r <= 1'b0;

      // A dropped strobe wins over a simultaneous clear.
      if (sample_stb && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        IDLE: begin
          if (sample_stb) begin
            state_r    <= SHIFT;
            shift_en_r <= 1'b1;
            acc_clr_r  <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
          end
        end
        SHIFT: begin
          state_r    <= MAC;
          tap_addr_r <= '0;
          busy_r     <= 1'b1;
        end
        MAC: begin
          if (tap_addr_r == TAP_LAST) begin
            tap_addr_r  <= '0;
            drain_cnt_r <= 3'd0;
            if (MUL_LAT == 0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= DRAIN;
            end
          end else begin
            tap_addr_r <= tap_addr_r + TAP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            drain_cnt_r <= 3'd0;
          end else begin
            drain_cnt_r <= drain_cnt_r + 3'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          tap_addr_r  <= '0;
          drain_cnt_r <= 3'd0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Issue flag delayed to line up with products reaching the accumulator.
  valid_delay #(
    .DEPTH (MUL_LAT)
  ) u_acc_en_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (issue_nxt_s),
    .dout (acc_en_s)
  );

  assign shift_en  = shift_en_r;
  assign tap_addr  = tap_addr_r;
  assign acc_clr   = acc_clr_r;
  assign acc_en    = acc_en_s;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: three instances (MUL_LAT 1, 0, 4)
// share all inputs; timelines are compared against hand-derived cycles and
// a small accumulator/coefficient model checks the impulse response.
module tb_fir_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_stb = 1'b0;
  logic ovr_clr = 1'b0;

  logic [2:0] se, clr, en, ov, bsy, ovr;
  logic [2:0] tap0, tap1, tap2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.cant_bits(25), .N_TAPS(8), .MUL_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .ovr_clr(ovr_clr),
    .shift_en(se[0]), .tap_addr(tap0), .acc_clr(clr[0]), .acc_en(en[0]),
    .out_valid(ov[0]), .busy(bsy[0]), .overrun(ovr[0]));

  fir_mac_sequencer #(.cant_bits(25), .N_TAPS(8), .MUL_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .ovr_clr(ovr_clr),
    .shift_en(se[1]), .tap_addr(tap1), .acc_clr(clr[1]), .acc_en(en[1]),
    .out_valid(ov[1]), .busy(bsy[1]), .overrun(ovr[1]));

  fir_mac_sequencer #(.cant_bits(25), .N_TAPS(8), .MUL_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .ovr_clr(ovr_clr),
    .shift_en(se[2]), .tap_addr(tap2), .acc_clr(clr[2]), .acc_en(en[2]),
    .out_valid(ov[2]), .busy(bsy[2]), .overrun(ovr[2]));

  // Reference datapath for the MUL_LAT=1 instance: delay line, ROM, 1-stage multiplier, accumulator.
  int h [0:7] = '{3, -5, 7, 11, -2, 13, 4, -1};
  int hist [0:7] = '{default: 0};
  int prod_r = 0;
  int m_acc = 0;
  int cur_sample = 0;

  always @(posedge clk) begin
    if (se[0]) begin
      for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= cur_sample;
    end
    prod_r <= h[tap0] * hist[tap0];
    if (clr[0]) m_acc <= 0;
    else if (en[0]) m_acc <= m_acc + prod_r;
  end

  // Per-cycle captures; bit i of the packed captures is instance i.
  logic [2:0] cap_se [0:31];
  logic [2:0] cap_clr [0:31];
  logic [2:0] cap_en [0:31];
  logic [2:0] cap_ov [0:31];
  logic [2:0] cap_bsy [0:31];
  logic [2:0] cap_ovr [0:31];
  logic [2:0] cap_tap [0:2][0:31];
  int         cap_acc [0:31];

  // Hand-derived timeline for N_TAPS=8, strobe at cycle 0, latency l.
  function automatic logic exp_en(input int c, input int l);
    return (c >= 2 + l) && (c <= 9 + l);
  endfunction
  function automatic logic exp_ov(input int c, input int l);
    return c == 10 + l;
  endfunction
  function automatic logic exp_bsy(input int c, input int l);
    return (c >= 1) && (c <= 10 + l);
  endfunction
  function automatic logic [2:0] exp_tap(input int c);
    return ((c >= 2) && (c <= 9)) ? 3'(c - 2) : 3'd0;
  endfunction

  // Runs n cycles, capturing at each negedge; strobes at 0 (if stb0) and at stb2, ovr_clr at clr_at.
  task automatic run_window(input int n, input bit stb0, input int stb2, input int clr_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_se[c] = se; cap_clr[c] = clr; cap_en[c] = en; cap_ov[c] = ov;
      cap_bsy[c] = bsy; cap_ovr[c] = ovr; cap_acc[c] = m_acc;
      cap_tap[0][c] = tap0; cap_tap[1][c] = tap1; cap_tap[2][c] = tap2;
      sample_stb = (stb0 && (c == 0)) || (c == stb2);
      ovr_clr = (c == clr_at);
    end
    @(negedge clk);
    sample_stb = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({se, clr, en, ov, bsy, ovr, tap0, tap1, tap2} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {se, clr, en, ov, bsy, ovr, tap0, tap1, tap2});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({se, clr, en, ov, bsy, ovr} !== 18'd0) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0", {se, clr, en, ov, bsy, ovr});
    end
  endtask

  task automatic test_single();
    run_window(16, 1'b1, -1, -1);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (cap_se[c][0] !== (c == 1)) begin failures++; $display("FAIL single_shift_en c=%0d got=%b exp=%b", c, cap_se[c][0], (c == 1)); end
      checks++;
      if (cap_clr[c][0] !== (c == 1)) begin failures++; $display("FAIL single_acc_clr c=%0d got=%b exp=%b", c, cap_clr[c][0], (c == 1)); end
      checks++;
      if (cap_tap[0][c] !== exp_tap(c)) begin failures++; $display("FAIL single_tap c=%0d got=%0d exp=%0d", c, cap_tap[0][c], exp_tap(c)); end
      checks++;
      if (cap_en[c][0] !== exp_en(c, 1)) begin failures++; $display("FAIL single_acc_en c=%0d got=%b exp=%b", c, cap_en[c][0], exp_en(c, 1)); end
      checks++;
      if (cap_ov[c][0] !== exp_ov(c, 1)) begin failures++; $display("FAIL single_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][0], exp_ov(c, 1)); end
      checks++;
      if (cap_bsy[c][0] !== exp_bsy(c, 1)) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, cap_bsy[c][0], exp_bsy(c, 1)); end
      checks++;
      if ((cap_clr[c][0] & cap_en[c][0]) !== 1'b0) begin failures++; $display("FAIL single_clr_en_overlap c=%0d got=1 exp=0", c); end
    end
  endtask

  task automatic test_latency();
    run_window(18, 1'b1, -1, -1);
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (cap_en[c][1] !== exp_en(c, 0)) begin failures++; $display("FAIL lat0_acc_en c=%0d got=%b exp=%b", c, cap_en[c][1], exp_en(c, 0)); end
      checks++;
      if (cap_ov[c][1] !== exp_ov(c, 0)) begin failures++; $display("FAIL lat0_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][1], exp_ov(c, 0)); end
      checks++;
      if (cap_tap[1][c] !== exp_tap(c)) begin failures++; $display("FAIL lat0_tap c=%0d got=%0d exp=%0d", c, cap_tap[1][c], exp_tap(c)); end
      checks++;
      if (cap_en[c][2] !== exp_en(c, 4)) begin failures++; $display("FAIL lat4_acc_en c=%0d got=%b exp=%b", c, cap_en[c][2], exp_en(c, 4)); end
      checks++;
      if (cap_ov[c][2] !== exp_ov(c, 4)) begin failures++; $display("FAIL lat4_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][2], exp_ov(c, 4)); end
      checks++;
      if (cap_bsy[c][2] !== exp_bsy(c, 4)) begin failures++; $display("FAIL lat4_busy c=%0d got=%b exp=%b", c, cap_bsy[c][2], exp_bsy(c, 4)); end
    end
  endtask

  task automatic test_back_to_back();
    run_window(26, 1'b1, 12, -1);
    for (int c = 0; c < 26; c++) begin
      logic e_se, e_en, e_ov;
      logic [2:0] e_tap;
      e_se  = (c == 1) || (c == 13);
      e_en  = exp_en(c, 1) || exp_en(c - 12, 1);
      e_ov  = exp_ov(c, 1) || exp_ov(c - 12, 1);
      e_tap = (c >= 14) ? exp_tap(c - 12) : exp_tap(c);
      checks++;
      if (cap_se[c][0] !== e_se) begin failures++; $display("FAIL b2b_shift_en c=%0d got=%b exp=%b", c, cap_se[c][0], e_se); end
      checks++;
      if (cap_en[c][0] !== e_en) begin failures++; $display("FAIL b2b_acc_en c=%0d got=%b exp=%b", c, cap_en[c][0], e_en); end
      checks++;
      if (cap_ov[c][0] !== e_ov) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][0], e_ov); end
      checks++;
      if (cap_tap[0][c] !== e_tap) begin failures++; $display("FAIL b2b_tap c=%0d got=%0d exp=%0d", c, cap_tap[0][c], e_tap); end
      checks++;
      if (cap_ovr[c][0] !== 1'b0) begin failures++; $display("FAIL b2b_overrun c=%0d got=%b exp=0", c, cap_ovr[c][0]); end
    end
  endtask

  task automatic test_overrun_drop();
    run_window(26, 1'b1, 11, -1);
    for (int c = 0; c < 26; c++) begin
      checks++;
      if (cap_se[c][0] !== (c == 1)) begin failures++; $display("FAIL drop_shift_en c=%0d got=%b exp=%b", c, cap_se[c][0], (c == 1)); end
      checks++;
      if (cap_ov[c][0] !== exp_ov(c, 1)) begin failures++; $display("FAIL drop_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][0], exp_ov(c, 1)); end
      checks++;
      if (cap_en[c][0] !== exp_en(c, 1)) begin failures++; $display("FAIL drop_acc_en c=%0d got=%b exp=%b", c, cap_en[c][0], exp_en(c, 1)); end
      checks++;
      if (cap_ovr[c][0] !== (c >= 12)) begin failures++; $display("FAIL drop_overrun c=%0d got=%b exp=%b", c, cap_ovr[c][0], (c >= 12)); end
    end
  endtask

  task automatic test_ovr_clr();
    // Clear with no strobe.
    run_window(4, 1'b0, -1, 1);
    checks++;
    if (cap_ovr[0][0] !== 1'b1) begin failures++; $display("FAIL clr_pre_overrun got=%b exp=1", cap_ovr[0][0]); end
    checks++;
    if (cap_ovr[2][0] !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", cap_ovr[2][0]); end
    // Clear in the same cycle as a dropped strobe: set wins.
    run_window(16, 1'b1, 3, 3);
    checks++;
    if (cap_ovr[3][0] !== 1'b0) begin failures++; $display("FAIL clr_set_before got=%b exp=0", cap_ovr[3][0]); end
    checks++;
    if (cap_ovr[4][0] !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", cap_ovr[4][0]); end
    checks++;
    if (cap_ovr[15][0] !== 1'b1) begin failures++; $display("FAIL clr_set_sticky got=%b exp=1", cap_ovr[15][0]); end
    checks++;
    if (cap_ov[11][0] !== 1'b1) begin failures++; $display("FAIL clr_run_out_valid got=%b exp=1", cap_ov[11][0]); end
  endtask

  task automatic test_reset_mid();
    run_window(6, 1'b1, -1, -1);
    // Window ends at the negedge of cycle 6 (mid MAC, tap 4).
    checks++;
    if (tap0 !== 3'd4) begin failures++; $display("FAIL rmid_pre_tap got=%0d exp=4", tap0); end
    rst = 1'b0;
    #1;
    checks++;
    if ({se, clr, en, ov, bsy, ovr, tap0, tap1, tap2} !== 27'd0) begin
      failures++;
      $display("FAIL rmid_outputs got=%b exp=0", {se, clr, en, ov, bsy, ovr, tap0, tap1, tap2});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_window(14, 1'b0, -1, -1);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if ((cap_en[c] | cap_bsy[c] | cap_ov[c]) !== 3'd0) begin
        failures++;
        $display("FAIL rmid_stray c=%0d got_en=%b got_busy=%b exp=0", c, cap_en[c], cap_bsy[c]);
      end
    end
    run_window(14, 1'b1, -1, -1);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (cap_tap[0][c] !== exp_tap(c)) begin failures++; $display("FAIL rmid_tap c=%0d got=%0d exp=%0d", c, cap_tap[0][c], exp_tap(c)); end
      checks++;
      if (cap_en[c][0] !== exp_en(c, 1)) begin failures++; $display("FAIL rmid_acc_en c=%0d got=%b exp=%b", c, cap_en[c][0], exp_en(c, 1)); end
      checks++;
      if (cap_ov[c][0] !== exp_ov(c, 1)) begin failures++; $display("FAIL rmid_out_valid c=%0d got=%b exp=%b", c, cap_ov[c][0], exp_ov(c, 1)); end
    end
  endtask

  task automatic test_impulse();
    for (int n = 0; n < 8; n++) begin
      cur_sample = (n == 0) ? 1 : 0;
      run_window(14, 1'b1, -1, -1);
      checks++;
      if (cap_ov[11][0] !== 1'b1) begin failures++; $display("FAIL impulse_valid n=%0d got=%b exp=1", n, cap_ov[11][0]); end
      checks++;
      if (cap_acc[11] !== h[n]) begin failures++; $display("FAIL impulse_sum n=%0d got=%0d exp=%0d", n, cap_acc[11], h[n]); end
    end
    cur_sample = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_back_to_back();
    test_overrun_drop();
    test_ovr_clr();
    test_reset_mid();
    test_impulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
